cla_pipe_adder: RTL and testbench

- Parametrised, pipelined two-level carry-lookahead adder/subtractor.
- Operands are split into GROUP-bit lookahead groups. Each group produces a group propagate and a group generate. A second-level lookahead unit combines these to produce every group carry-in.
- The datapath sits behind a valid/ready handshake, so it drops into streaming ALU paths. It is the successor to the fixed 4-bit lookahead adder.

---
 rtl/cla_pipe_adder.sv | 242 ++++++++++++++++++++++++
 tb/tb_cla_pipe_adder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined two-level carry-lookahead adder/subtractor
//
// Purpose: WIDTH-bit add/subtract. The operands are split into GROUP-bit
// lookahead groups, and a second-level lookahead unit produces every group
// carry-in. The datapath sits behind a valid/ready handshake driven by one
// global advance signal. Latency is STAGES cycles.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready      input beat handshake
//   a, b, cin, sub           operands, carry/borrow-in, 0 = add, 1 = subtract
//   out_valid / out_ready    output beat handshake
//   sum, cout, ovf           result, raw MSB carry, signed overflow
//   stat_xfers, stat_stalls  output transfer count and stall-cycle count
//
// Optional feature: define CLA_PIPE_STATS_EN to build the saturating
// statistics counters. When it is undefined, both stat ports read 0.

module cla_pipe_adder #(
   parameter int WIDTH  = 16,
   parameter int GROUP  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic [31:0]      stat_xfers,
   output logic [31:0]      stat_stalls
);
   localparam int NG = WIDTH / GROUP;

   logic             adv;
   logic             out_valid_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q, ovf_q;

   // Every stage holds together while the output register is blocked.
   assign adv      = !out_valid_q || out_ready;
   assign in_ready = adv;

   // Stage 0: effective operand, bit p/g, and group P/G.
   logic [WIDTH-1:0] b_eff, s0_p, s0_g;
   logic [NG-1:0]    s0_pg, s0_gg;
   logic             s0_c0;
   logic             g_term, g_acc;

   assign b_eff = sub ? ~b : b;
   assign s0_c0 = sub ? ~cin : cin;
   assign s0_p  = a ^ b_eff;
   assign s0_g  = a & b_eff;

   always_comb begin
      s0_pg  = '0;
      s0_gg  = '0;
      g_term = 1'b0;
      g_acc  = 1'b0;
      for (int k = 0; k < NG; k++) begin
         s0_pg[k] = &s0_p[k*GROUP +: GROUP];
         g_acc = 1'b0;
         for (int j = 0; j < GROUP; j++) begin
            g_term = s0_g[k*GROUP+j];
            for (int m = j + 1; m < GROUP; m++) g_term = g_term & s0_p[k*GROUP+m];
            g_acc = g_acc | g_term;
         end
         s0_gg[k] = g_acc;
      end
   end

   // Stage 1 boundary: registered when STAGES >= 2.
   logic [WIDTH-1:0] s1_p, s1_g;
   logic [NG-1:0]    s1_pg, s1_gg;
   logic             s1_c0, s1_v;

   generate
      if (STAGES >= 2) begin : g_s1_reg
         logic [WIDTH-1:0] p_q, g_q;
         logic [NG-1:0]    pg_q, gg_q;
         logic             c0_q, v_q;
         always_ff @(posedge clk) begin
            if (rst)      v_q <= 1'b0;
            else if (adv) v_q <= in_valid;
         end
         always_ff @(posedge clk) begin
            if (adv) begin
               p_q  <= s0_p;
               g_q  <= s0_g;
               pg_q <= s0_pg;
               gg_q <= s0_gg;
               c0_q <= s0_c0;
            end
         end
         assign s1_p  = p_q;
         assign s1_g  = g_q;
         assign s1_pg = pg_q;
         assign s1_gg = gg_q;
         assign s1_c0 = c0_q;
         assign s1_v  = v_q;
      end else begin : g_s1_thru
         assign s1_p  = s0_p;
         assign s1_g  = s0_g;
         assign s1_pg = s0_pg;
         assign s1_gg = s0_gg;
         assign s1_c0 = s0_c0;
         assign s1_v  = in_valid;
      end
   endgenerate

   // Second-level lookahead: each group carry-in is a flat sum of products.
   // s1_gc[NG] is the carry out of the MSB.
   logic [NG:0] s1_gc;
   logic        c_term, c_acc;

   always_comb begin
      s1_gc    = '0;
      c_term   = 1'b0;
      c_acc    = 1'b0;
      s1_gc[0] = s1_c0;
      for (int k = 1; k <= NG; k++) begin
         c_term = s1_c0;
         for (int m = 0; m < k; m++) c_term = c_term & s1_pg[m];
         c_acc = c_term;
         for (int j = 0; j < k; j++) begin
            c_term = s1_gg[j];
            for (int m = j + 1; m < k; m++) c_term = c_term & s1_pg[m];
            c_acc = c_acc | c_term;
         end
         s1_gc[k] = c_acc;
      end
   end

   // Stage 2 boundary: group carries are registered only when STAGES == 3.
   logic [WIDTH-1:0] s2_p, s2_g;
   logic [NG:0]      s2_gc;
   logic             s2_v;

   generate
      if (STAGES >= 3) begin : g_s2_reg
         logic [WIDTH-1:0] p_q, g_q;
         logic [NG:0]      gc_q;
         logic             v_q;
         always_ff @(posedge clk) begin
            if (rst)      v_q <= 1'b0;
            else if (adv) v_q <= s1_v;
         end
         always_ff @(posedge clk) begin
            if (adv) begin
               p_q  <= s1_p;
               g_q  <= s1_g;
               gc_q <= s1_gc;
            end
         end
         assign s2_p  = p_q;
         assign s2_g  = g_q;
         assign s2_gc = gc_q;
         assign s2_v  = v_q;
      end else begin : g_s2_thru
         assign s2_p  = s1_p;
         assign s2_g  = s1_g;
         assign s2_gc = s1_gc;
         assign s2_v  = s1_v;
      end
   endgenerate

   // In-group bit carries, again as full lookahead from the group carry-in.
   logic [WIDTH-1:0] s2_c, s2_sum;
   logic             b_term, b_acc, s2_ovf;

   always_comb begin
      s2_c   = '0;
      b_term = 1'b0;
      b_acc  = 1'b0;
      for (int k = 0; k < NG; k++) begin
         for (int i = 0; i < GROUP; i++) begin
            b_term = s2_gc[k];
            for (int m = 0; m < i; m++) b_term = b_term & s2_p[k*GROUP+m];
            b_acc = b_term;
            for (int j = 0; j < i; j++) begin
               b_term = s2_g[k*GROUP+j];
               for (int m = j + 1; m < i; m++) b_term = b_term & s2_p[k*GROUP+m];
               b_acc = b_acc | b_term;
            end
            s2_c[k*GROUP+i] = b_acc;
         end
      end
   end

   assign s2_sum = s2_p ^ s2_c;
   // When the MSBs of a and b' agree, p_msb is 0 and g_msb is their shared value.
   assign s2_ovf = !s2_p[WIDTH-1] && (s2_sum[WIDTH-1] != s2_g[WIDTH-1]);

   // The output data registers load only with a real beat, so they read 0
   // after reset until the first result arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
         cout_q      <= 1'b0;
         ovf_q       <= 1'b0;
      end else if (adv) begin
         out_valid_q <= s2_v;
         if (s2_v) begin
            sum_q  <= s2_sum;
            cout_q <= s2_gc[NG];
            ovf_q  <= s2_ovf;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

`ifdef CLA_PIPE_STATS_EN
   logic [31:0] xfers_q, stalls_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         xfers_q  <= '0;
         stalls_q <= '0;
      end else begin
         if (out_valid_q && out_ready && (xfers_q != '1))   xfers_q  <= xfers_q + 32'd1;
         if (out_valid_q && !out_ready && (stalls_q != '1)) stalls_q <= stalls_q + 32'd1;
      end
   end
   assign stat_xfers  = xfers_q;
   assign stat_stalls = stalls_q;
`else
   assign stat_xfers  = '0;
   assign stat_stalls = '0;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - self-checking bench for cla_pipe_adder

module tb_cla_pipe_adder;
   localparam int NSWEEP = 1000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;
   logic [31:0] stat_xfers, stat_stalls;

   logic        sw_valid, sw_cin, sw_sub, sw_ready;
   logic [31:0] sw_a, sw_b;
   logic        r1_in_ready, r1_out_valid, r1_cout, r1_ovf;
   logic [15:0] r1_sum;
   logic [31:0] r1_sx, r1_ss;
   logic        r3_in_ready, r3_out_valid, r3_cout, r3_ovf;
   logic [31:0] r3_sum;
   logic [31:0] r3_sx, r3_ss;

   int checks = 0;
   int errors = 0;

   cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf),
      .stat_xfers(stat_xfers), .stat_stalls(stat_stalls)
   );

   cla_pipe_adder #(.WIDTH(16), .GROUP(2), .STAGES(1)) u_dut_s1 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r1_in_ready),
      .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub),
      .out_valid(r1_out_valid), .out_ready(sw_ready),
      .sum(r1_sum), .cout(r1_cout), .ovf(r1_ovf),
      .stat_xfers(r1_sx), .stat_stalls(r1_ss)
   );

   cla_pipe_adder #(.WIDTH(32), .GROUP(8), .STAGES(3)) u_dut_s3 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(r3_in_ready),
      .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub),
      .out_valid(r3_out_valid), .out_ready(sw_ready),
      .sum(r3_sum), .cout(r3_cout), .ovf(r3_ovf),
      .stat_xfers(r3_sx), .stat_stalls(r3_ss)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: {ovf, cout, sum} from plain integer arithmetic.
   function automatic logic [63:0] ref_calc(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                            input logic ci, input logic si);
      longint unsigned mask, bb, full;
      longint          sa, sb, r, lim;
      logic [63:0]     res;
      mask = (64'd1 << w) - 64'd1;
      bb   = si ? ((~{32'd0, bi}) & mask) : {32'd0, bi};
      full = {32'd0, ai} + bb + ((si ? !ci : ci) ? 64'd1 : 64'd0);
      sa = longint'({32'd0, ai});
      sb = longint'({32'd0, bi});
      if (ai[w-1]) sa = sa - (longint'(1) << w);
      if (bi[w-1]) sb = sb - (longint'(1) << w);
      r   = si ? (sa - sb - longint'({63'd0, ci})) : (sa + sb + longint'({63'd0, ci}));
      lim = longint'(1) << (w - 1);
      res = full & ((mask << 1) | 64'd1);
      if ((r >= lim) || (r < -lim)) res = res | (64'd1 << (w + 1));
      return res;
   endfunction

   task automatic run_beat(input string tag, input logic [15:0] ai, input logic [15:0] bi,
                           input logic ci, input logic si,
                           input logic [15:0] es, input logic ec, input logic eo);
      int lat;
      @(posedge clk); #1;
      a = ai; b = bi; cin = ci; sub = si; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 10);
      check({tag, " latency"}, 64'(lat), 64'd2);
      check({tag, " result"}, {46'd0, ovf, cout, sum}, {46'd0, eo, ec, es});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : main
      logic        sweep_v [NSWEEP+4];
      logic [63:0] e16 [NSWEEP+4];
      logic [63:0] e32 [NSWEEP+4];
      logic [63:0] exp_v;
      logic [15:0] held, ta, tb;
      logic [31:0] x0, s0;
      logic        stale;
      int          sent, rcvd, cyc;

      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
      sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset sum", 64'(sum), 64'd0);
      check("reset cout/ovf", 64'({cout, ovf}), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd1);
      check("reset stat_xfers", 64'(stat_xfers), 64'd0);
      check("reset stat_stalls", 64'(stat_stalls), 64'd0);

      run_beat("add 2+3",        16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0, 1'b0);
      run_beat("add FFFF+1",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_beat("add 7FFF+1",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_beat("sub A-4",        16'h000A, 16'h0004, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0);
      run_beat("sub 4-A-1",      16'h0004, 16'h000A, 1'b1, 1'b1, 16'hFFF9, 1'b0, 1'b0);
      run_beat("add 8000+8000",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_beat("sub 8000-1",     16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_beat("add 1234+4321+1",16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

      // Streaming with a 3-cycle downstream hold.
      x0 = stat_xfers; s0 = stat_stalls;
      sent = 0; rcvd = 0; cyc = 0; held = '0;
      while (rcvd < 8 && cyc < 40) begin
         @(posedge clk); #1;
         out_ready = !(cyc >= 4 && cyc <= 6);
         in_valid  = (sent < 8);
         a   = 16'h1111 * sent[15:0];
         b   = 16'h0F0F + sent[15:0];
         cin = sent[0];
         sub = 1'b0;
         @(negedge clk);
         if (!out_ready) begin
            check("hold in_ready", 64'(in_ready), 64'd0);
            check("hold out_valid", 64'(out_valid), 64'd1);
            if (cyc == 4) held = sum;
            else check("hold sum stable", 64'(sum), 64'(held));
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            ta = 16'h1111 * rcvd[15:0];
            tb = 16'h0F0F + rcvd[15:0];
            exp_v = ref_calc(16, {16'd0, ta}, {16'd0, tb}, rcvd[0], 1'b0);
            check("stream beat", {46'd0, ovf, cout, sum}, exp_v);
            rcvd++;
         end
         cyc++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      check("stream count", 64'(rcvd), 64'd8);
`ifdef CLA_PIPE_STATS_EN
      check("stat_xfers delta", 64'(stat_xfers - x0), 64'd8);
      check("stat_stalls delta", 64'(stat_stalls - s0), 64'd3);
`else
      check("stat_xfers tied", 64'(stat_xfers), 64'd0);
      check("stat_stalls tied", 64'(stat_stalls), 64'd0);
`endif

      // Reset with two beats in flight (one held at the output, one behind it).
      out_ready = 1'b0;
      a = 16'h0011; b = 16'h0022; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      a = 16'h0033; b = 16'h0044;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check("mid reset out_valid", 64'(out_valid), 64'd0);
      check("mid reset sum", 64'(sum), 64'd0);
      check("mid reset in_ready", 64'(in_ready), 64'd1);
      check("mid reset stats", 64'({stat_xfers, stat_stalls}), 64'd0);
      stale = 1'b0;
      repeat (4) begin
         @(negedge clk);
         stale = stale | out_valid;
      end
      check("no stale output", 64'(stale), 64'd0);
      run_beat("after reset", 16'h0100, 16'h00FF, 1'b1, 1'b0, 16'h0200, 1'b0, 1'b0);

      // Random sweep of the STAGES=1/GROUP=2 and STAGES=3/GROUP=8 instances.
      for (int t = 0; t < NSWEEP + 3; t++) begin
         @(posedge clk); #1;
         sw_valid = (t < NSWEEP) && ($urandom_range(0, 4) != 0);
         sw_a   = $urandom;
         sw_b   = $urandom;
         sw_cin = 1'($urandom_range(0, 1));
         sw_sub = 1'($urandom_range(0, 1));
         sweep_v[t] = sw_valid;
         e16[t] = ref_calc(16, {16'd0, sw_a[15:0]}, {16'd0, sw_b[15:0]}, sw_cin, sw_sub);
         e32[t] = ref_calc(32, sw_a, sw_b, sw_cin, sw_sub);
         @(negedge clk);
         if (t >= 1) begin
            check("s1 valid", 64'(r1_out_valid), 64'(sweep_v[t-1]));
            if (sweep_v[t-1]) check("s1 result", {46'd0, r1_ovf, r1_cout, r1_sum}, e16[t-1]);
         end else begin
            check("s1 idle", 64'(r1_out_valid), 64'd0);
         end
         if (t >= 3) begin
            check("s3 valid", 64'(r3_out_valid), 64'(sweep_v[t-3]));
            if (sweep_v[t-3]) check("s3 result", {30'd0, r3_ovf, r3_cout, r3_sum}, e32[t-3]);
         end else begin
            check("s3 idle", 64'(r3_out_valid), 64'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
